gate_reduce_unit: RTL and testbench

GATE_REDUCE_UNIT -- requirements
Module: gate_reduce_unit

---
 rtl/gate_reduce_unit.sv | 115 +++++++++++
 tb/tb_gate_reduce_unit.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_reduce_unit.sv
// gate_reduce_unit: folds NUM_OPS operands through a bitwise gate function
// (AND/OR/XOR and their inverted forms) and presents one result at a time.
//
// Handshake: an operand transfers on a rising edge where in_valid && in_ready;
// a result transfers on a rising edge where out_valid && out_ready. in_ready
// and busy are decoded from the state register only, so neither has a
// combinational path from in_valid or out_ready.
module gate_reduce_unit #(
    parameter int WIDTH   = 8,
    parameter int NUM_OPS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       op_sel,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    localparam int CW = $clog2(NUM_OPS + 1);

    // Refuse to build degenerate configurations.
    generate
        if (NUM_OPS < 2 || WIDTH < 1) begin : g_bad_params
            $error("gate_reduce_unit: NUM_OPS must be >= 2 and WIDTH >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    cnt;
    logic [2:0]       op_q;

    logic             accept;
    logic [WIDTH-1:0] fold_val;
    logic             invert_q;

    assign accept    = in_valid && in_ready;
    assign in_ready  = (state != S_HOLD);
    assign busy      = (state != S_IDLE);
    assign dbg_state = state;

    // Inverted variants apply the inversion once, to the final result only.
    assign invert_q = (op_q == 3'b011) || (op_q == 3'b100) || (op_q == 3'b101);

    // Base gate of the latched function applied to the running value.
    always_comb begin
        fold_val = acc & in_data;
        case (op_q)
            3'b001, 3'b100: fold_val = acc | in_data;
            3'b010, 3'b101: fold_val = acc ^ in_data;
            default:        fold_val = acc & in_data;
        endcase
    end

    // Reduction FSM with registered result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            acc       <= '0;
            cnt       <= '0;
            op_q      <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        acc   <= in_data;
                        op_q  <= op_sel;
                        cnt   <= CW'(1);
                        state <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (accept) begin
                        acc <= fold_val;
                        cnt <= cnt + CW'(1);
                        if (cnt == CW'(NUM_OPS - 1)) begin
                            state     <= S_HOLD;
                            out_valid <= 1'b1;
                            out_data  <= invert_q ? ~fold_val : fold_val;
                        end
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        state     <= S_IDLE;
                        cnt       <= '0;
                        out_valid <= 1'b0;
                        out_data  <= '0;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    cnt       <= '0;
                    out_valid <= 1'b0;
                    out_data  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_reduce_unit.sv
// Directed bench for gate_reduce_unit: an 8-bit/4-operand instance and a
// 1-bit/2-operand instance sharing clock and reset.
module tb_gate_reduce_unit;

    // Clock and reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Main instance (WIDTH=8, NUM_OPS=4)
    logic [2:0] op_sel = 3'b000;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       busy;
    logic [1:0] dbg_state;

    gate_reduce_unit #(.WIDTH(8), .NUM_OPS(4)) dut (
        .clk(clk), .rst_n(rst_n), .op_sel(op_sel), .in_valid(in_valid),
        .in_ready(in_ready), .in_data(in_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .busy(busy),
        .dbg_state(dbg_state)
    );

    // Small instance (WIDTH=1, NUM_OPS=2)
    logic [2:0] op_sel2 = 3'b000;
    logic       in_valid2 = 1'b0;
    logic       in_ready2;
    logic [0:0] in_data2 = 1'b0;
    logic       out_valid2;
    logic       out_ready2 = 1'b0;
    logic [0:0] out_data2;
    logic       busy2;
    logic [1:0] dbg_state2;

    gate_reduce_unit #(.WIDTH(1), .NUM_OPS(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .op_sel(op_sel2), .in_valid(in_valid2),
        .in_ready(in_ready2), .in_data(in_data2), .out_valid(out_valid2),
        .out_ready(out_ready2), .out_data(out_data2), .busy(busy2),
        .dbg_state(dbg_state2)
    );

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one operand for exactly one rising edge, then release in_valid.
    task automatic send(input logic [7:0] d, input logic [2:0] op);
        in_valid = 1'b1;
        in_data  = d;
        op_sel   = op;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    // Consume the held result of the main instance.
    task automatic drain;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    logic exp_bit;
    logic base_bit;

    initial begin
        // Reset state (held asynchronously)
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_busy", busy, 0);
        check("rst_state", dbg_state, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle_cycles(1);

        // AND: A5 & FF & F0 & 3C = 20
        send(8'hA5, 3'b000);
        check("and_busy_after_first", busy, 1);
        send(8'hFF, 3'b000);
        send(8'hF0, 3'b000);
        check("and_no_early_valid", out_valid, 0);
        check("and_early_data_zero", out_data, 0);
        send(8'h3C, 3'b000);
        check("and_valid", out_valid, 1);
        check("and_data", out_data, 8'h20);
        check("and_busy_hold", busy, 1);
        check("and_in_ready_hold", in_ready, 0);
        check("and_state_hold", dbg_state, 2);
        drain();
        check("and_valid_fall", out_valid, 0);
        check("and_data_zero", out_data, 0);
        check("and_busy_fall", busy, 0);
        check("and_in_ready_back", in_ready, 1);

        // XNOR: 0F ^ F0 ^ FF ^ 00 = 00, inverted -> FF
        send(8'h0F, 3'b101);
        send(8'hF0, 3'b101);
        send(8'hFF, 3'b101);
        send(8'h00, 3'b101);
        check("xnor_valid", out_valid, 1);
        check("xnor_data", out_data, 8'hFF);
        drain();

        // XOR on the same operands -> 00
        send(8'h0F, 3'b010);
        send(8'hF0, 3'b010);
        send(8'hFF, 3'b010);
        send(8'h00, 3'b010);
        check("xor_valid", out_valid, 1);
        check("xor_data", out_data, 8'h00);
        drain();

        // NOR latched at first operand, op_sel switched to AND afterwards,
        // with bubbles of 0..3 cycles: ~(01|02|04|08) = F0
        send(8'h01, 3'b100);
        idle_cycles(1);
        send(8'h02, 3'b000);
        idle_cycles(3);
        check("nor_no_valid_mid", out_valid, 0);
        send(8'h04, 3'b000);
        idle_cycles(2);
        check("nor_no_valid_after3", out_valid, 0);
        check("nor_busy_gap", busy, 1);
        send(8'h08, 3'b000);
        check("nor_valid", out_valid, 1);
        check("nor_data", out_data, 8'hF0);
        drain();

        // Backpressure: OR 11|22|44|08 = 7F, then stall with in_valid high
        send(8'h11, 3'b001);
        send(8'h22, 3'b001);
        send(8'h44, 3'b001);
        send(8'h08, 3'b001);
        in_valid = 1'b1;
        in_data  = 8'hAA;
        op_sel   = 3'b000;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_in_ready", in_ready, 0);
            check("bp_valid", out_valid, 1);
            check("bp_data", out_data, 8'h7F);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_release_valid", out_valid, 0);
        check("bp_release_ready", in_ready, 1);
        check("bp_release_busy", busy, 0);
        // AA still offered: accepted now as the first operand of a new AND.
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_new_start_busy", busy, 1);
        send(8'h0F, 3'b000);
        send(8'hFF, 3'b000);
        check("bp_new_not_done", out_valid, 0);
        send(8'hFF, 3'b000);
        check("bp_new_valid", out_valid, 1);
        check("bp_new_data", out_data, 8'h0A);
        drain();

        // Reset mid-reduction after 2 of 4 operands
        send(8'h00, 3'b000);
        send(8'h00, 3'b000);
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid", out_valid, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_ready", in_ready, 1);
        check("rst_mid_state", dbg_state, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset while a result is held
        send(8'h12, 3'b001);
        send(8'h34, 3'b001);
        send(8'h56, 3'b001);
        send(8'h78, 3'b001);
        check("rst_hold_pre_valid", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_hold_valid", out_valid, 0);
        check("rst_hold_data", out_data, 0);
        check("rst_hold_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Fresh AND of four FF operands, no contamination
        send(8'hFF, 3'b000);
        send(8'hFF, 3'b000);
        send(8'hFF, 3'b000);
        check("fresh_not_done", out_valid, 0);
        send(8'hFF, 3'b000);
        check("fresh_valid", out_valid, 1);
        check("fresh_data", out_data, 8'hFF);
        drain();

        // Sweep on the 1-bit, 2-operand instance: all op codes and pairs
        for (int op = 0; op < 8; op++) begin
            for (int a = 0; a < 2; a++) begin
                for (int b = 0; b < 2; b++) begin
                    case (op)
                        1, 4:    base_bit = 1'(a | b);
                        2, 5:    base_bit = 1'(a ^ b);
                        default: base_bit = 1'(a & b);
                    endcase
                    exp_bit = (op == 3 || op == 4 || op == 5) ? ~base_bit : base_bit;
                    op_sel2   = 3'(op);
                    in_valid2 = 1'b1;
                    in_data2  = 1'(a);
                    @(posedge clk); #1;
                    in_data2  = 1'(b);
                    op_sel2   = 3'(~op);
                    @(posedge clk); #1;
                    in_valid2 = 1'b0;
                    check($sformatf("sweep_valid_op%0d_%0d%0d", op, a, b), out_valid2, 1);
                    check($sformatf("sweep_data_op%0d_%0d%0d", op, a, b), out_data2, exp_bit);
                    out_ready2 = 1'b1;
                    @(posedge clk); #1;
                    out_ready2 = 1'b0;
                end
            end
        end
        check("sweep_end_idle", busy2, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
